// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : load_store_unit_pkg                                          |
// | Purpose  : Shared constants for the load/store unit. Includes the       |
// |            RV32I opcode and func3 encodings, the LSU state encoding,    |
// |            the byte-lane masks and func3 legality helpers.              |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package load_store_unit_pkg;

   // RV32I major opcodes handled by the LSU
   localparam logic [6:0] c_op_l   = 7'b0000011;
   localparam logic [6:0] c_op_s   = 7'b0100011;

   // Load func3 encodings
   localparam logic [2:0] c_f3_lb  = 3'b000;
   localparam logic [2:0] c_f3_lh  = 3'b001;
   localparam logic [2:0] c_f3_lw  = 3'b010;
   localparam logic [2:0] c_f3_lbu = 3'b100;
   localparam logic [2:0] c_f3_lhu = 3'b101;

   // Store func3 encodings
   localparam logic [2:0] c_f3_sb  = 3'b000;
   localparam logic [2:0] c_f3_sh  = 3'b001;
   localparam logic [2:0] c_f3_sw  = 3'b010;

   // func3[1:0] gives the access size for both loads and stores
   localparam logic [1:0] c_size_b = 2'b00;
   localparam logic [1:0] c_size_h = 2'b01;
   localparam logic [1:0] c_size_w = 2'b10;

   // Byte-lane masks before shifting into position
   localparam logic [3:0] c_lane_b = 4'b0001;
   localparam logic [3:0] c_lane_h = 4'b0011;
   localparam logic [3:0] c_lane_w = 4'b1111;

   // LSU state encoding (2-bit)
   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_t;

   // True when func3 is a legal encoding for the given operation class
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      if (is_store) begin
         ok = (f3 == c_f3_sb) || (f3 == c_f3_sh) || (f3 == c_f3_sw);
      end else begin
         ok = (f3 == c_f3_lb)  || (f3 == c_f3_lh)  || (f3 == c_f3_lw) ||
              (f3 == c_f3_lbu) || (f3 == c_f3_lhu);
      end
      return ok;
   endfunction

endpackage : load_store_unit_pkg
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : lsu_load_align                                              |
// | Purpose  : Combinational load-data aligner. Selects the addressed       |
// |            byte/half of the raw memory word and sign- or zero-extends   |
// |            it according to func3.                                      |
// | Ports    : func3  in  3   load func3                                   |
// |            a      in  2   byte offset within the word                  |
// |            rdata  in  32  raw read word                                |
// |            result out 32  aligned/extended load value                  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module lsu_load_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  a,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = rdata[7:0];
      case (a)
         2'd0:    w_byte = rdata[7:0];
         2'd1:    w_byte = rdata[15:8];
         2'd2:    w_byte = rdata[23:16];
         default: w_byte = rdata[31:24];
      endcase
   end

   // a[0] is ignored for halves: the top level has already aligned it
   assign w_half = a[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      result = 32'd0;
      case (func3)
         c_f3_lb:  result = {{24{w_byte[7]}}, w_byte};
         c_f3_lh:  result = {{16{w_half[15]}}, w_half};
         c_f3_lw:  result = rdata;
         c_f3_lbu: result = {24'd0, w_byte};
         c_f3_lhu: result = {16'd0, w_half};
         default:  result = 32'd0;
      endcase
   end

endmodule : lsu_load_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : load_store_unit                                             |
// | Purpose  : RV32I load/store unit. Accepts one EX-stage request, drives  |
// |            a req/gnt/rvalid data-memory port with byte enables, aligns  |
// |            and extends load data, and returns a one-cycle writeback.    |
// | Config   : MISALIGN_TRAP_EN - when defined, misaligned half/word ops    |
// |            complete with err=1 without touching memory; otherwise the   |
// |            low address bits are forced to natural alignment.           |
// | Params   : ADDR_W   data-memory address width                          |
// |            MAX_WAIT cycles allowed in REQ/WAIT before error (0 = none)  |
// | Ports    : clk, rst_n (async active-low)                               |
// |            EX side : req_valid, req_ready, opcode, func3, alu_addr,     |
// |                      st_data, rd_in                                    |
// |            Memory  : dm_req, dm_we, dm_addr, dm_wdata, dm_gnt,          |
// |                      dm_rvalid, dm_rdata                               |
// |            WB side : wb_valid, wb_we, wb_rd, wb_data, err               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 255
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [6:0]        opcode,
   input  logic [2:0]        func3,
   input  logic [31:0]       alu_addr,
   input  logic [31:0]       st_data,
   input  logic [4:0]        rd_in,
   output logic              dm_req,
   output logic [3:0]        dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_wdata,
   input  logic              dm_gnt,
   input  logic              dm_rvalid,
   input  logic [31:0]       dm_rdata,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              err
);

   localparam int             CNT_W      = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] c_max_wait = CNT_W'(MAX_WAIT);

   // ---------------------------------------------------------------------
   // State and latched request
   // ---------------------------------------------------------------------
   lsu_state_t        r_state;
   logic              r_is_load;
   logic [2:0]        r_f3;
   logic [1:0]        r_a_lo;
   logic [4:0]        r_rd;
   logic [CNT_W-1:0]  r_cnt;

   logic              r_req_ready;
   logic              r_dm_req;
   logic [3:0]        r_dm_we;
   logic [ADDR_W-1:0] r_dm_addr;
   logic [31:0]       r_dm_wdata;
   logic              r_wb_valid;
   logic              r_wb_we;
   logic [4:0]        r_wb_rd;
   logic [31:0]       r_wb_data;
   logic              r_err;

   // ---------------------------------------------------------------------
   // Request decode (only meaningful in IDLE)
   // ---------------------------------------------------------------------
   logic              w_is_load;
   logic              w_is_store;
   logic              w_accept;
   logic              w_trap;
   logic [1:0]        w_size;
   logic [1:0]        w_a_lo;
   logic [3:0]        w_we;
   logic [31:0]       w_wdata;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_timeout;
   logic [31:0]       w_load_data;

   assign w_is_load  = (opcode == c_op_l);
   assign w_is_store = (opcode == c_op_s);
   assign w_accept   = req_valid && r_req_ready && (w_is_load || w_is_store);
   assign w_size     = func3[1:0];

`ifdef MISALIGN_TRAP_EN
   logic w_misal;
   assign w_misal = ((w_size == c_size_h) && alu_addr[0]) ||
                    ((w_size == c_size_w) && (alu_addr[1:0] != 2'b00));
   assign w_trap  = !f3_legal(w_is_store, func3) || w_misal;
`else
   assign w_trap  = !f3_legal(w_is_store, func3);
`endif

   // Offset forced to natural alignment; with the trap enabled a misaligned
   // op never reaches here, so forcing is a no-op in that build.
   always_comb begin
      w_a_lo = 2'b00;
      case (w_size)
         c_size_b: w_a_lo = alu_addr[1:0];
         c_size_h: w_a_lo = {alu_addr[1], 1'b0};
         default:  w_a_lo = 2'b00;
      endcase
   end

   always_comb begin
      w_we    = 4'b0000;
      w_wdata = 32'd0;
      if (w_is_store) begin
         case (w_size)
            c_size_b: begin
               w_we    = c_lane_b << w_a_lo;
               w_wdata = {4{st_data[7:0]}};
            end
            c_size_h: begin
               w_we    = c_lane_h << w_a_lo;
               w_wdata = {2{st_data[15:0]}};
            end
            c_size_w: begin
               w_we    = c_lane_w;
               w_wdata = st_data;
            end
            default: begin
               w_we    = 4'b0000;
               w_wdata = 32'd0;
            end
         endcase
      end
   end

   // Timeout fires on the cycle the count would reach MAX_WAIT
   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_timeout = (MAX_WAIT != 0) && (w_cnt_inc == c_max_wait);

   lsu_load_align u_align (
      .func3  (r_f3),
      .a      (r_a_lo),
      .rdata  (dm_rdata),
      .result (w_load_data)
   );

   // ---------------------------------------------------------------------
   // FSM with registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= LSU_IDLE;
         r_is_load   <= 1'b0;
         r_f3        <= 3'd0;
         r_a_lo      <= 2'd0;
         r_rd        <= 5'd0;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_dm_req    <= 1'b0;
         r_dm_we     <= 4'b0000;
         r_dm_addr   <= '0;
         r_dm_wdata  <= 32'd0;
         r_wb_valid  <= 1'b0;
         r_wb_we     <= 1'b0;
         r_wb_rd     <= 5'd0;
         r_wb_data   <= 32'd0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            LSU_IDLE: begin
               if (w_accept) begin
                  r_is_load   <= w_is_load;
                  r_f3        <= func3;
                  r_a_lo      <= w_a_lo;
                  r_rd        <= w_is_load ? rd_in : 5'd0;
                  r_cnt       <= '0;
                  r_req_ready <= 1'b0;
                  if (w_trap) begin
                     // Illegal or trapped op: report without a memory access
                     r_state    <= LSU_DONE;
                     r_wb_valid <= 1'b1;
                     r_wb_we    <= 1'b0;
                     r_wb_rd    <= w_is_load ? rd_in : 5'd0;
                     r_wb_data  <= 32'd0;
                     r_err      <= 1'b1;
                  end else begin
                     r_state    <= LSU_REQ;
                     r_dm_req   <= 1'b1;
                     r_dm_we    <= w_we;
                     r_dm_addr  <= {alu_addr[ADDR_W-1:2], 2'b00};
                     r_dm_wdata <= w_wdata;
                  end
               end
            end

            LSU_REQ: begin
               if (dm_gnt) begin
                  r_dm_req <= 1'b0;
                  r_dm_we  <= 4'b0000;
                  if (!r_is_load) begin
                     r_state    <= LSU_DONE;
                     r_wb_valid <= 1'b1;
                     r_wb_we    <= 1'b0;
                     r_wb_rd    <= r_rd;
                     r_wb_data  <= 32'd0;
                  end else if (dm_rvalid) begin
                     // Zero-latency memory: grant and data in the same cycle
                     r_state    <= LSU_DONE;
                     r_wb_valid <= 1'b1;
                     r_wb_we    <= 1'b1;
                     r_wb_rd    <= r_rd;
                     r_wb_data  <= w_load_data;
                  end else begin
                     r_state <= LSU_WAIT;
                     r_cnt   <= '0;
                  end
               end else if (w_timeout) begin
                  r_state    <= LSU_DONE;
                  r_dm_req   <= 1'b0;
                  r_dm_we    <= 4'b0000;
                  r_wb_valid <= 1'b1;
                  r_wb_we    <= 1'b0;
                  r_wb_rd    <= r_rd;
                  r_wb_data  <= 32'd0;
                  r_err      <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            LSU_WAIT: begin
               if (dm_rvalid) begin
                  r_state    <= LSU_DONE;
                  r_wb_valid <= 1'b1;
                  r_wb_we    <= 1'b1;
                  r_wb_rd    <= r_rd;
                  r_wb_data  <= w_load_data;
               end else if (w_timeout) begin
                  r_state    <= LSU_DONE;
                  r_wb_valid <= 1'b1;
                  r_wb_we    <= 1'b0;
                  r_wb_rd    <= r_rd;
                  r_wb_data  <= 32'd0;
                  r_err      <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            default: begin
               // LSU_DONE: writeback pulse lasts exactly one cycle
               r_state     <= LSU_IDLE;
               r_req_ready <= 1'b1;
               r_wb_valid  <= 1'b0;
               r_wb_we     <= 1'b0;
               r_wb_rd     <= 5'd0;
               r_wb_data   <= 32'd0;
               r_err       <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign dm_req    = r_dm_req;
   assign dm_we     = r_dm_we;
   assign dm_addr   = r_dm_addr;
   assign dm_wdata  = r_dm_wdata;
   assign wb_valid  = r_wb_valid;
   assign wb_we     = r_wb_we;
   assign wb_rd     = r_wb_rd;
   assign wb_data   = r_wb_data;
   assign err       = r_err;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_load_store_unit                                          |
// | Purpose  : Directed self-checking bench for load_store_unit.           |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_load_store_unit;

   localparam logic [6:0] OPL = 7'b0000011;
   localparam logic [6:0] OPS = 7'b0100011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [31:0] alu_addr;
   logic [31:0] st_data;
   logic [4:0]  rd_in;
   logic        dm_req;
   logic [3:0]  dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32), .MAX_WAIT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .opcode(opcode), .func3(func3), .alu_addr(alu_addr),
      .st_data(st_data), .rd_in(rd_in),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Present one request for a single cycle, then scramble the inputs so
   // that any reliance on unlatched values shows up.
   task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
      req_valid = 1'b1; opcode = op; func3 = f3; alu_addr = a; st_data = d; rd_in = rd;
      tick();
      req_valid = 1'b0; func3 = 3'b111; alu_addr = 32'hFFFF_FFFC; st_data = 32'h0; rd_in = 5'd31;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; opcode = 7'd0; func3 = 3'd0; alu_addr = 32'd0;
      st_data = 32'd0; rd_in = 5'd0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;
      tick(); tick();
      // Reset state
      chk("rst_ready",   {31'd0, req_ready}, 32'd1);
      chk("rst_dm_req",  {31'd0, dm_req},    32'd0);
      chk("rst_dm_we",   {28'd0, dm_we},     32'd0);
      chk("rst_dm_addr", dm_addr,            32'd0);
      chk("rst_wb",      {29'd0, wb_valid, wb_we, err}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: SW a=0x100, grant after two cycles
      issue(OPS, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0);
      chk("sw_req",   {31'd0, dm_req},    32'd1);
      chk("sw_ready", {31'd0, req_ready}, 32'd0);
      chk("sw_we",    {28'd0, dm_we},     32'h0000_000F);
      chk("sw_addr",  dm_addr,            32'h0000_0100);
      chk("sw_wdata", dm_wdata,           32'hDEAD_BEEF);
      tick();
      chk("sw_hold",  {31'd0, dm_req},    32'd1);
      dm_gnt = 1'b1;
      tick();
      dm_gnt = 1'b0;
      chk("sw_done",  {29'd0, wb_valid, wb_we, err}, 32'b100);
      chk("sw_rqoff", {31'd0, dm_req},    32'd0);
      tick();
      chk("sw_idle",  {30'd0, req_ready, wb_valid}, 32'b10);

      // 2: SB a=0x103
      issue(OPS, 3'b000, 32'h103, 32'h0000_00A5, 5'd0);
      chk("sb_we",    {28'd0, dm_we}, 32'h0000_0008);
      chk("sb_wdata", dm_wdata,       32'hA5A5_A5A5);
      chk("sb_addr",  dm_addr,        32'h0000_0100);
      dm_gnt = 1'b1; tick(); dm_gnt = 1'b0;
      chk("sb_done",  {29'd0, wb_valid, wb_we, err}, 32'b100);
      tick();

      // 3a: LB a=0x102, one-cycle rvalid after grant
      issue(OPL, 3'b000, 32'h102, 32'h0, 5'd5);
      chk("lb_we", {28'd0, dm_we}, 32'd0);
      dm_gnt = 1'b1; tick(); dm_gnt = 1'b0;
      chk("lb_wait", {30'd0, dm_req, wb_valid}, 32'b00);
      dm_rvalid = 1'b1; dm_rdata = 32'h12F4_5678; tick(); dm_rvalid = 1'b0;
      chk("lb_wbv",  {30'd0, wb_valid, wb_we}, 32'b11);
      chk("lb_rd",   {27'd0, wb_rd},           32'd5);
      chk("lb_data", wb_data,                  32'hFFFF_FFF4);
      tick();

      // 3b: LBU a=0x102, grant and data in the same cycle
      issue(OPL, 3'b100, 32'h102, 32'h0, 5'd6);
      dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h12F4_5678;
      tick(); dm_gnt = 1'b0; dm_rvalid = 1'b0;
      chk("lbu_data", wb_data, 32'h0000_00F4);
      chk("lbu_wbv",  {30'd0, wb_valid, err}, 32'b10);
      tick();

      // 3c: LH a=0x102
      issue(OPL, 3'b001, 32'h102, 32'h0, 5'd7);
      dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h12F4_5678;
      tick(); dm_gnt = 1'b0; dm_rvalid = 1'b0;
      chk("lh_data", wb_data, 32'h0000_12F4);
      tick();

      // 3d: LH / LHU a=0x100 with negative half
      issue(OPL, 3'b001, 32'h100, 32'h0, 5'd8);
      dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h1234_ABCD;
      tick(); dm_gnt = 1'b0; dm_rvalid = 1'b0;
      chk("lh_neg", wb_data, 32'hFFFF_ABCD);
      tick();
      issue(OPL, 3'b101, 32'h100, 32'h0, 5'd8);
      dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h1234_ABCD;
      tick(); dm_gnt = 1'b0; dm_rvalid = 1'b0;
      chk("lhu_data", wb_data, 32'h0000_ABCD);
      tick();

      // 4: LW with no grant, MAX_WAIT=8
      issue(OPL, 3'b010, 32'h200, 32'h0, 5'd9);
      for (int i = 0; i < 8; i++) begin
         chk("to_req", {31'd0, dm_req}, 32'd1);
         tick();
      end
      chk("to_rqoff", {31'd0, dm_req},              32'd0);
      chk("to_done",  {29'd0, wb_valid, wb_we, err}, 32'b101);
      dm_rvalid = 1'b1; dm_rdata = 32'h5555_5555;
      tick(); dm_rvalid = 1'b0;
      chk("to_idle",  {29'd0, req_ready, wb_valid, err}, 32'b100);

      // 5: LW a=0x101
      issue(OPL, 3'b010, 32'h101, 32'h0, 5'd10);
`ifdef MISALIGN_TRAP_EN
      chk("mis_noreq", {31'd0, dm_req},              32'd0);
      chk("mis_done",  {29'd0, wb_valid, wb_we, err}, 32'b101);
`else
      chk("mis_addr",  dm_addr,          32'h0000_0100);
      chk("mis_req",   {31'd0, dm_req},  32'd1);
      dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
      tick(); dm_gnt = 1'b0; dm_rvalid = 1'b0;
      chk("mis_done",  {29'd0, wb_valid, wb_we, err}, 32'b110);
      chk("mis_data",  wb_data,          32'hCAFE_F00D);
`endif
      tick();

      // Illegal func3 inside OP_S: next-cycle error, no memory access
      issue(OPS, 3'b011, 32'h100, 32'h1, 5'd0);
      chk("bad_f3", {28'd0, dm_req, wb_valid, wb_we, err}, 32'b0101);
      tick();

      // Non-memory opcode is never accepted
      issue(7'b0110011, 3'b010, 32'h100, 32'h1, 5'd1);
      chk("bad_op", {30'd0, req_ready, dm_req}, 32'b10);

      // 6: reset during WAIT
      issue(OPL, 3'b010, 32'h300, 32'h0, 5'd3);
      dm_gnt = 1'b1; tick(); dm_gnt = 1'b0;
      chk("rw_wait", {30'd0, req_ready, dm_req}, 32'b00);
      #1 rst_n = 1'b0;
      #1;
      chk("rw_ready", {31'd0, req_ready}, 32'd1);
      chk("rw_addr",  dm_addr,            32'd0);
      chk("rw_outs",  {27'd0, dm_req, dm_we}, 32'd0);
      tick();
      rst_n = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h7777_7777;
      tick(); dm_rvalid = 1'b0;
      chk("rw_drop",  {29'd0, req_ready, wb_valid, err}, 32'b100);
      chk("rw_data",  wb_data, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_load_store_unit
`default_nettype wire
